booth_multiplier_seq: RTL
=========================

Name: booth_multiplier_seq

Overview:
Iterative, parametrised radix-4 Booth multiplier that produces the full 2*width-bit product over several clock cycles instead of one combinational cascade. It retires digits_per_cycle radix-4 Booth digits per clock. It sits in the execute stage behind a valid/ready handshake, serving RISC-V MUL/MULH/MULHSU/MULHU (and the W variants at width 32). It adds a tag passthrough and a flush to abandon the in-flight operation on pipeline kill.

Parameters:
width, 64, operand width in bits; must be even and >= 4
digits_per_cycle, 1, radix-4 Booth digits retired per clock; must divide width/2
tag_width, 5, width of opaque tag carried from request to result

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of any accepted or in-flight operation
in_valid  in  1  request valid
in_ready  out  1  request can be accepted
arg1  in  width  multiplicand
arg1_is_signed  in  1  arg1 is two's complement
arg2  in  width  multiplier (Booth-recoded operand)
arg2_is_signed  in  1  arg2 is two's complement
in_tag  in  tag_width  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
mul  out  width  product bits [width-1:0]
mulh  out  width  product bits [2*width-1:width]
out_tag  out  tag_width  tag of the result

Behaviour:
- Reset: state IDLE. in_ready=0 while reset is asserted and 1 after. out_valid=0. mul, mulh, out_tag and internal accumulators=0. Counter=0.
- Cycles per op: C = width/(2*digits_per_cycle); 32 at the defaults.
- Accept on the clock edge where in_valid && in_ready && !flush. Latch:
  - a = {arg1_is_signed & arg1[width-1], arg1}, width+1 bits, signed
  - r = {arg2_is_signed & arg2[width-1], arg2}, width+1 bits, signed
  - in_tag
  - Clear the accumulator, set the implicit r[-1]=0, and go to BUSY with counter=0.
- BUSY, per cycle, for each of digits_per_cycle digits j (LSB first):
  - Digit from triplet {r[2j+1], r[2j], r[2j-1]} maps to {0,+1,+1,+2,-2,-1,-1,0} x a.
  - Add the digit x a, sign-extended, into the upper accumulator.
  - Arithmetic-shift the accumulator right by 2 and consume 2 bits of r.
  - counter++. When counter == C-1 completes, go to DONE.
- DONE: out_valid=1. mul/mulh equal the two's-complement 2*width-bit product under the latched signedness. out_tag equals the latched tag. Outputs are stable while out_valid && !out_ready.
- Leave DONE on out_valid && out_ready: go to IDLE, or straight to BUSY if a new request is accepted the same edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational in out_ready; no combinational path from in_valid.
- Throughput: one op per C+1 cycles under back-to-back traffic with out_ready=1. Result appears C cycles after the accept edge.
- flush=1 at an edge:
  - State goes to IDLE and out_valid=0 next cycle.
  - A request presented in the same cycle is not accepted.
  - A DONE result not yet handshaken is dropped.
  - in_ready is forced 0 while flush=1.
- reset mid-op: immediate return to reset values; no partial result is ever presented.
- Arithmetic: the accumulator is 2*width+2 bits, which is enough to hold the ±2a digit without overflow. Unsigned x unsigned with both MSBs set must produce a correct mulh via the width+1 extension.
- Inputs are sampled only at the accept edge. Changes to arg*/in_tag during BUSY have no effect.

Test Plan:
- Defaults, 0xffffffffffffffff x 0xffffffffffffffff:
  - signed/signed -> mul=0x1, mulh=0x0
  - unsigned/unsigned -> mul=0x1, mulh=0xfffffffffffffffe
  - signed arg1, unsigned arg2 -> mul=0x1, mulh=0xffffffffffffffff
  - out_valid exactly 32 cycles after accept
- digits_per_cycle=4: 0xa0b6b8129b5bdfd9 x 0xbcba1c1981093535, all four signedness combos.
  - Results match a 128-bit reference model.
  - out_valid 8 cycles after accept.
  - out_tag equals in_tag (e.g. 5'h13).
- Back-pressure: hold out_ready=0 for 10 cycles in DONE.
  - mul/mulh/out_tag stable, in_ready=0.
  - Raise out_ready with in_valid=1: result retires and the new op is accepted on the same edge.
- flush at BUSY cycle 5:
  - out_valid never rises for that op.
  - in_ready=1 the next cycle.
  - A following 0x2 x 0x3 op yields mul=0x6, mulh=0x0 and its own tag.
- Async reset asserted mid-BUSY (between edges):
  - out_valid=0, mul=mulh=0 immediately.
  - in_ready=1 after deassert.
  - No stale result appears.
- width=32, digits_per_cycle=2, randomized 1000 ops with random valid/ready/flush.
  - Every retired result matches the reference model and its tag, in order.
  - No duplicated or lost non-flushed ops.

Source files
------------

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier for the execute stage.
// Retires digits_per_cycle Booth digits per clock behind valid/ready
// handshakes, carries an opaque tag, and abandons work on flush.
// The accumulator holds the partial product scaled so that every step
// adds a digit multiple into the upper half and then arithmetic-shifts
// right by two; after width/2 digits it holds the full product.
module booth_multiplier_seq #(
  parameter int width            = 64,
  parameter int digits_per_cycle = 1,
  parameter int tag_width        = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     arg1,
  input  logic                 arg1_is_signed,
  input  logic [width-1:0]     arg2,
  input  logic                 arg2_is_signed,
  input  logic [tag_width-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     mul,
  output logic [width-1:0]     mulh,
  output logic [tag_width-1:0] out_tag
);

  localparam int Cycles = width / (2 * digits_per_cycle);
  localparam int CntW   = $clog2(Cycles) + 1;
  localparam int AccW   = 2 * width + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [width:0]       a_q, a_d;
  logic [width:0]       r_q, r_d;
  logic                 rm1_q, rm1_d;
  logic                 corr_q, corr_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [tag_width-1:0] tag_q, tag_d;
  logic                 out_valid_q, out_valid_d;
  logic [width-1:0]     mul_q, mul_d;
  logic [width-1:0]     mulh_q, mulh_d;
  logic [tag_width-1:0] out_tag_q, out_tag_d;

  logic [AccW-1:0]      acc_v;
  logic [width:0]       r_v;
  logic                 rm1_v;
  logic [width+2:0]     sum_v;
  logic [2*width-1:0]   fin_v;
  logic                 in_ready_s;
  logic                 accept_s;

  // Partial product for one Booth triplet {r[2j+1], r[2j], r[2j-1]}:
  // {0,+1,+1,+2,-2,-1,-1,0} times a, returned sign-extended to width+3 bits.
  function automatic logic [width+2:0] booth_pp(input logic [2:0] trip,
                                                input logic [width:0] a);
    logic [width+2:0] a_ext;
    logic [width+2:0] pp;
    a_ext = {{2{a[width]}}, a};
    case (trip)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = {a_ext[width+1:0], 1'b0};
      3'b100:         pp = ~{a_ext[width+1:0], 1'b0} + {{(width+2){1'b0}}, 1'b1};
      3'b101, 3'b110: pp = ~a_ext + {{(width+2){1'b0}}, 1'b1};
      default:        pp = {(width+3){1'b0}};
    endcase
    return pp;
  endfunction

  // Next-state, Booth datapath step and handshake decode.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    r_d         = r_q;
    rm1_d       = rm1_q;
    corr_d      = corr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    mul_d       = mul_q;
    mulh_d      = mulh_q;
    out_tag_d   = out_tag_q;

    // Retire digits_per_cycle digits, LSB first. The add is done one bit
    // wider than the stored upper half; after the shift it fits again.
    acc_v = acc_q;
    r_v   = r_q;
    rm1_v = rm1_q;
    sum_v = {(width+3){1'b0}};
    for (int j = 0; j < digits_per_cycle; j++) begin
      sum_v = {acc_v[AccW-1], acc_v[AccW-1:width]} + booth_pp({r_v[1], r_v[0], rm1_v}, a_q);
      acc_v = {sum_v[width+2], sum_v, acc_v[width-1:2]};
      rm1_v = r_v[1];
      r_v   = {{2{r_v[width]}}, r_v[width:2]};
    end

    // The width/2 digits only cover r[width-1:0] as a signed value. An
    // unsigned multiplier with its MSB set needs one more digit (+1 at
    // weight 2^width), applied here as a*2^width on the final product.
    fin_v = acc_v[2*width-1:0] + (corr_q ? {a_q[width-1:0], {width{1'b0}}}
                                         : {(2*width){1'b0}});

    in_ready_s = !reset && !flush &&
                 ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept_s   = in_valid && in_ready_s;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        BUSY: begin
          acc_d = acc_v;
          r_d   = r_v;
          rm1_d = rm1_v;
          cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
          if (cnt_q == CntW'(Cycles - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            mul_d       = fin_v[width-1:0];
            mulh_d      = fin_v[2*width-1:width];
            out_tag_d   = tag_q;
          end else begin
            state_d = BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase

      if (accept_s) begin
        state_d = BUSY;
        a_d     = {arg1_is_signed & arg1[width-1], arg1};
        r_d     = {arg2_is_signed & arg2[width-1], arg2};
        corr_d  = !arg2_is_signed & arg2[width-1];
        rm1_d   = 1'b0;
        acc_d   = {AccW{1'b0}};
        cnt_d   = {CntW{1'b0}};
        tag_d   = in_tag;
      end else begin
        tag_d = tag_d;
      end
    end
  end

  // All state and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= {(width+1){1'b0}};
      r_q         <= {(width+1){1'b0}};
      rm1_q       <= 1'b0;
      corr_q      <= 1'b0;
      acc_q       <= {AccW{1'b0}};
      cnt_q       <= {CntW{1'b0}};
      tag_q       <= {tag_width{1'b0}};
      out_valid_q <= 1'b0;
      mul_q       <= {width{1'b0}};
      mulh_q      <= {width{1'b0}};
      out_tag_q   <= {tag_width{1'b0}};
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      r_q         <= r_d;
      rm1_q       <= rm1_d;
      corr_q      <= corr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      mul_q       <= mul_d;
      mulh_q      <= mulh_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign mul       = mul_q;
  assign mulh      = mulh_q;
  assign out_tag   = out_tag_q;

endmodule
